// File: rtl/arbitro_escrita_obstaculos_if.sv
// rtl/arbitro_escrita_obstaculos_if.sv - requester/sweep side and obstacle-memory write port of the arbiter
interface arbitro_escrita_obstaculos_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req_in;
    logic [ADDR_WIDTH*NUM_REQ-1:0] addr_in;
    logic [NUM_REQ-1:0]            data_in;
    logic [NUM_REQ-1:0]            grant_out;
    logic                          clear_start_in;
    logic                          busy_out;
    logic                          clear_done_out;
    logic                          obstaculos_wr_enable_out;
    logic [ADDR_WIDTH-1:0]         obstaculos_wr_addr_out;
    logic                          obstaculos_wr_data_out;

    modport master (
        output req_in, addr_in, data_in, clear_start_in,
        input  grant_out, busy_out, clear_done_out,
        input  obstaculos_wr_enable_out, obstaculos_wr_addr_out, obstaculos_wr_data_out
    );

    modport slave (
        input  req_in, addr_in, data_in, clear_start_in,
        output grant_out, busy_out, clear_done_out,
        output obstaculos_wr_enable_out, obstaculos_wr_addr_out, obstaculos_wr_data_out
    );
endinterface

// File: rtl/arbitro_escrita_obstaculos.sv
// rtl/arbitro_escrita_obstaculos.sv - round-robin arbiter for the obstacle write port; sweep clear under ARBITRO_OBSTACULOS_CLEAR_EN
module arbitro_escrita_obstaculos #(
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REQ    = 4
) (
    input logic                          clk,
    input logic                          rst,
    arbitro_escrita_obstaculos_if.slave  bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]      ptr;
    logic [NUM_REQ-1:0]    eligible;
    logic                  found;
    logic [PTR_W-1:0]      winner;
    logic [PTR_W-1:0]      next_ptr;
    logic [NUM_REQ-1:0]    win_onehot;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic                  win_data;
    int                    idx;

    // The mask keeps a requester that is still visible during its grant cycle out of this round.
    always_comb begin
        eligible = bus.req_in & ~bus.grant_out;
        found    = 1'b0;
        winner   = '0;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
        next_ptr   = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
        win_onehot = NUM_REQ'(1) << winner;
        win_addr   = bus.addr_in[winner*ADDR_WIDTH +: ADDR_WIDTH];
        win_data   = bus.data_in[winner];
    end

`ifdef ARBITRO_OBSTACULOS_CLEAR_EN
    typedef enum logic {S_IDLE, S_CLEAR} state_t;
    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                        <= S_IDLE;
            ptr                          <= '0;
            cnt                          <= '0;
            bus.grant_out                <= '0;
            bus.busy_out                 <= 1'b0;
            bus.clear_done_out           <= 1'b0;
            bus.obstaculos_wr_enable_out <= 1'b0;
            bus.obstaculos_wr_addr_out   <= '0;
            bus.obstaculos_wr_data_out   <= 1'b0;
        end else begin
            bus.grant_out                <= '0;
            bus.busy_out                 <= 1'b0;
            bus.clear_done_out           <= 1'b0;
            bus.obstaculos_wr_enable_out <= 1'b0;
            bus.obstaculos_wr_addr_out   <= '0;
            bus.obstaculos_wr_data_out   <= 1'b0;
            if (state == S_IDLE && bus.clear_start_in) begin
                state                        <= S_CLEAR;
                cnt                          <= '0;
                bus.busy_out                 <= 1'b1;
                bus.obstaculos_wr_enable_out <= 1'b1;
            end else if (state == S_CLEAR && cnt != '1) begin
                cnt                          <= cnt + 1'b1;
                bus.busy_out                 <= 1'b1;
                bus.obstaculos_wr_enable_out <= 1'b1;
                bus.obstaculos_wr_addr_out   <= cnt + 1'b1;
            end else begin
                // Leaving the sweep shares this edge with the first stalled grant.
                if (state == S_CLEAR) begin
                    state              <= S_IDLE;
                    bus.clear_done_out <= 1'b1;
                end
                if (found) begin
                    bus.grant_out                <= win_onehot;
                    bus.obstaculos_wr_enable_out <= 1'b1;
                    bus.obstaculos_wr_addr_out   <= win_addr;
                    bus.obstaculos_wr_data_out   <= win_data;
                    ptr                          <= next_ptr;
                end
            end
        end
    end
`else
    assign bus.busy_out       = 1'b0;
    assign bus.clear_done_out = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr                          <= '0;
            bus.grant_out                <= '0;
            bus.obstaculos_wr_enable_out <= 1'b0;
            bus.obstaculos_wr_addr_out   <= '0;
            bus.obstaculos_wr_data_out   <= 1'b0;
        end else begin
            bus.grant_out                <= '0;
            bus.obstaculos_wr_enable_out <= 1'b0;
            bus.obstaculos_wr_addr_out   <= '0;
            bus.obstaculos_wr_data_out   <= 1'b0;
            if (found) begin
                bus.grant_out                <= win_onehot;
                bus.obstaculos_wr_enable_out <= 1'b1;
                bus.obstaculos_wr_addr_out   <= win_addr;
                bus.obstaculos_wr_data_out   <= win_data;
                ptr                          <= next_ptr;
            end
        end
    end
`endif
endmodule

// File: tb/tb_arbitro_escrita_obstaculos.sv
// tb/tb_arbitro_escrita_obstaculos.sv - scoreboard bench for arbitro_escrita_obstaculos
module tb_arbitro_escrita_obstaculos;
    localparam int AW    = 4;
    localparam int NR    = 4;
    localparam int DEPTH = 1 << AW;
`ifdef ARBITRO_OBSTACULOS_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [NR-1:0] grant;
        logic          en;
        logic [AW-1:0] addr;
        logic          data;
        logic          busy;
        logic          done;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    arbitro_escrita_obstaculos_if #(.ADDR_WIDTH(AW), .NUM_REQ(NR)) bus ();

    arbitro_escrita_obstaculos #(.ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cycle = 0;
    obs_t exp_q[$];

    // Reference state: fairness pointer, grant shown this cycle, and sweep progress.
    int            m_ptr   = 0;
    logic [NR-1:0] m_grant = '0;
    bit            m_clr   = 1'b0;
    int            m_next  = 0;

    function automatic obs_t actual();
        obs_t a;
        a.grant = bus.grant_out;
        a.en    = bus.obstaculos_wr_enable_out;
        a.addr  = bus.obstaculos_wr_addr_out;
        a.data  = bus.obstaculos_wr_data_out;
        a.busy  = bus.busy_out;
        a.done  = bus.clear_done_out;
        return a;
    endfunction

    function automatic int pick(input logic [NR-1:0] elig, input int p);
        for (int k = 0; k < NR; k++)
            if (elig[(p + k) % NR]) return (p + k) % NR;
        return -1;
    endfunction

    task automatic check(input string name, input obs_t a, input obs_t e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got grant=%b en=%b addr=%h data=%b busy=%b done=%b, want grant=%b en=%b addr=%h data=%b busy=%b done=%b",
                     name, cycle, a.grant, a.en, a.addr, a.data, a.busy, a.done,
                     e.grant, e.en, e.addr, e.data, e.busy, e.done);
        end
    endtask

    always @(posedge clk) begin
        obs_t e;
        int   w;
        e = '0;
        cycle++;
        if (rst) begin
            m_ptr = 0;
            m_clr = 1'b0;
            m_next = 0;
        end else if (m_clr && m_next < DEPTH) begin
            e.en = 1'b1; e.addr = AW'(m_next); e.busy = 1'b1;
            m_next++;
        end else if (!m_clr && CLR_EN && bus.clear_start_in) begin
            m_clr = 1'b1; m_next = 1;
            e.en = 1'b1; e.busy = 1'b1;
        end else begin
            if (m_clr) begin
                m_clr = 1'b0;
                e.done = 1'b1;
            end
            w = pick(bus.req_in & ~m_grant, m_ptr);
            if (w >= 0) begin
                e.grant[w] = 1'b1;
                e.en   = 1'b1;
                e.addr = bus.addr_in[w*AW +: AW];
                e.data = bus.data_in[w];
                m_ptr  = (w + 1) % NR;
            end
        end
        m_grant = e.grant;
        exp_q.push_back(e);
    end

    always @(posedge clk) begin
        #1;
        if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard cycle %0d: got empty queue, want an entry", cycle);
        end else begin
            check("cycle_out", actual(), exp_q.pop_front());
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic async_reset_check(input string name);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check(name, actual(), '0);
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic d);
        bus.addr_in[i*AW +: AW] = a;
        bus.data_in[i] = d;
    endtask

    initial begin
        rst = 1'b1;
        bus.req_in = '0; bus.addr_in = '0; bus.data_in = '0; bus.clear_start_in = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, AW'(i + 8), 1'(i % 2));
        bus.req_in = 4'b1111;
        cyc(2);
        rst = 1'b0;
        cyc(10);

        async_reset_check("async_reset_rr");
        cyc(6);

        bus.req_in = 4'b0100;
        set_req(2, 4'hC, 1'b1);
        cyc(10);

        bus.req_in = 4'b0010;
        set_req(1, 4'h5, 1'b1);
        bus.clear_start_in = 1'b1;
        cyc(1);
        bus.clear_start_in = 1'b0;
        cyc(22);

        bus.req_in = 4'b1001;
        bus.clear_start_in = 1'b1;
        cyc(1);
        bus.clear_start_in = 1'b0;
        cyc(5);
        bus.clear_start_in = 1'b1;
        cyc(1);
        bus.clear_start_in = 1'b0;
        cyc(18);

        bus.clear_start_in = 1'b1;
        cyc(1);
        bus.clear_start_in = 1'b0;
        cyc(8);
        async_reset_check("async_reset_sweep");
        cyc(20);

        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!bus.req_in[i]) begin
                    if ($urandom_range(2) == 0) begin
                        bus.req_in[i] = 1'b1;
                        set_req(i, AW'($urandom), 1'($urandom));
                    end
                end else if (m_grant[i]) begin
                    if ($urandom_range(1) == 0) bus.req_in[i] = 1'b0;
                    else set_req(i, AW'($urandom), 1'($urandom));
                end
            end
            bus.clear_start_in = ($urandom_range(59) == 0);
            cyc(1);
        end
        bus.clear_start_in = 1'b0;
        bus.req_in = '0;
        cyc(DEPTH + 4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
